// File: rtl/stack_cpu_pkg.sv
// Shared constants, opcodes and FSM state encoding
// for the 8-bit stack processor controller.
package stack_cpu_pkg;

  localparam int STACK_DEPTH_DEF = 32;
  localparam int DEPTH_W_DEF     = 6;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_IF,
    S_ID,
    S_P1,
    S_P2,
    S_LB,
    S_LA1,
    S_EX,
    S_MRD,
    S_PW,
    S_PO,
    S_ST,
    S_JMP,
    S_TOS,
    S_JZC,
    S_FAULT
  } state_e;

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter with the pop/push
// feasibility flags consulted at decode.
import stack_cpu_pkg::*;

module stack_depth_tracker #(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int DEPTH_W     = DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               can_pop1_o,
  output logic               can_pop2_o,
  output logic               can_push_o
);

  localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO  = DEPTH_W'(2);
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;

  always_comb begin
    depth_d = depth_q;
    unique case ({push_i, pop_i})
      2'b10:   depth_d = depth_q + ONE;
      2'b01:   depth_d = depth_q - ONE;
      default: depth_d = depth_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) depth_q <= '0;
    else     depth_q <= depth_d;
  end

  assign depth_o    = depth_q;
  assign can_pop1_o = depth_q >= ONE;
  assign can_pop2_o = depth_q >= TWO;
  assign can_push_o = depth_q < FULL;

endmodule

// File: rtl/stack_cpu_controller.sv
// Multicycle Moore controller for the stack CPU:
// fetch/decode, stack strobes, memory and PC control.
import stack_cpu_pkg::*;

module stack_cpu_controller #(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int DEPTH_W     = DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic               push,
  output logic               pop,
  output logic               tos,
  output logic               memRead,
  output logic               memWrite,
  output logic               iorD,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               pcSrc,
  output logic               ldA,
  output logic               ldB,
  output logic               ldMdr,
  output logic               stkSrc,
  output logic [1:0]         aluOp,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault
);

  state_e state_q;
  state_e state_d;
  logic   can_pop1;
  logic   can_pop2;
  logic   can_push;

  stack_depth_tracker #(
    .STACK_DEPTH(STACK_DEPTH),
    .DEPTH_W    (DEPTH_W)
  ) u_depth (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .depth_o   (depth),
    .can_pop1_o(can_pop1),
    .can_pop2_o(can_pop2),
    .can_push_o(can_push)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pop      = 1'b0;
    tos      = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    iorD     = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    ldMdr    = 1'b0;
    stkSrc   = 1'b0;
    aluOp    = ALU_ADD;
    fault    = 1'b0;
    unique case (state_q)
      S_IF: begin
        memRead = 1'b1;
        irWrite = 1'b1;
        pcWrite = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        unique case (opcode)
          OP_ADD, OP_SUB, OP_AND:
            state_d = can_pop2 ? S_P1 : S_FAULT;
          OP_NOT:  state_d = can_pop1 ? S_P1 : S_FAULT;
          OP_PUSH: state_d = can_push ? S_MRD : S_FAULT;
          OP_POP:  state_d = can_pop1 ? S_PO : S_FAULT;
          OP_JMP:  state_d = S_JMP;
          OP_JZ:   state_d = can_pop1 ? S_TOS : S_FAULT;
        endcase
      end
      S_P1: begin
        pop     = 1'b1;
        state_d = (opcode == OP_NOT) ? S_LA1 : S_P2;
      end
      S_P2: begin
        pop     = 1'b1;
        ldA     = 1'b1;
        state_d = S_LB;
      end
      S_LB: begin
        ldB     = 1'b1;
        state_d = S_EX;
      end
      S_LA1: begin
        ldA     = 1'b1;
        state_d = S_EX;
      end
      S_EX: begin
        push    = 1'b1;
        // opcode low bits share the aluOp encoding
        aluOp   = opcode[1:0];
        state_d = S_IF;
      end
      S_MRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        ldMdr   = 1'b1;
        state_d = S_PW;
      end
      S_PW: begin
        push    = 1'b1;
        stkSrc  = 1'b1;
        state_d = S_IF;
      end
      S_PO: begin
        pop     = 1'b1;
        state_d = S_ST;
      end
      S_ST: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        state_d  = S_IF;
      end
      S_JMP: begin
        pcWrite = 1'b1;
        pcSrc   = 1'b1;
        state_d = S_IF;
      end
      S_TOS: begin
        tos     = 1'b1;
        state_d = S_JZC;
      end
      S_JZC: begin
        pcWrite = zero;
        pcSrc   = zero;
        state_d = S_IF;
      end
      S_FAULT: begin
        fault   = 1'b1;
        state_d = S_FAULT;
      end
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Directed scoreboard bench for the stack CPU
// controller: per-cycle control vector and depth.
import stack_cpu_pkg::*;

module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       push, pop, tos;
  logic       memRead, memWrite, iorD;
  logic       irWrite, pcWrite, pcSrc;
  logic       ldA, ldB, ldMdr, stkSrc;
  logic [1:0] aluOp;
  logic [5:0] depth;
  logic       fault;

  always #5 clk = ~clk;

  stack_cpu_controller dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .memRead (memRead),
    .memWrite(memWrite),
    .iorD    (iorD),
    .irWrite (irWrite),
    .pcWrite (pcWrite),
    .pcSrc   (pcSrc),
    .ldA     (ldA),
    .ldB     (ldB),
    .ldMdr   (ldMdr),
    .stkSrc  (stkSrc),
    .aluOp   (aluOp),
    .depth   (depth),
    .fault   (fault)
  );

  localparam logic [15:0] C_PUSH = 16'h8000;
  localparam logic [15:0] C_POP  = 16'h4000;
  localparam logic [15:0] C_TOS  = 16'h2000;
  localparam logic [15:0] C_MRD  = 16'h1000;
  localparam logic [15:0] C_MWR  = 16'h0800;
  localparam logic [15:0] C_IORD = 16'h0400;
  localparam logic [15:0] C_IRW  = 16'h0200;
  localparam logic [15:0] C_PCW  = 16'h0100;
  localparam logic [15:0] C_PCS  = 16'h0080;
  localparam logic [15:0] C_LDA  = 16'h0040;
  localparam logic [15:0] C_LDB  = 16'h0020;
  localparam logic [15:0] C_LDM  = 16'h0010;
  localparam logic [15:0] C_STK  = 16'h0008;
  localparam logic [15:0] C_FLT  = 16'h0001;
  localparam logic [15:0] C_IF   = C_MRD | C_IRW | C_PCW;

  logic [15:0] ctrl;
  assign ctrl = {push, pop, tos, memRead, memWrite, iorD,
                 irWrite, pcWrite, pcSrc, ldA, ldB, ldMdr,
                 stkSrc, aluOp, fault};

  typedef struct {
    logic [15:0] c;
    logic [5:0]  d;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   mdepth;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [15:0] alu(input logic [1:0] a);
    return {13'b0, a, 1'b0};
  endfunction

  task automatic expect_cyc(input logic [15:0] c, input string tag);
    exp_t e;
    e.c   = c;
    e.d   = 6'(mdepth);
    e.tag = tag;
    sb.push_back(e);
    if (c[15]) mdepth++;
    if (c[14]) mdepth--;
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (ctrl === e.c) else begin
        failures++;
        $error("FAIL %s ctrl obs=%h exp=%h", e.tag, ctrl, e.c);
      end
      checks++;
      assert (depth === e.d) else begin
        failures++;
        $error("FAIL %s depth obs=%0d exp=%0d", e.tag, depth, e.d);
      end
      checks++;
      assert ($onehot0({push, pop, tos})) else begin
        failures++;
        $error("FAIL %s strobes obs=%b exp=onehot0", e.tag,
               {push, pop, tos});
      end
      @(negedge clk);
    end
  endtask

  task automatic instr(input logic [2:0] op, input logic z,
                       input string tag);
    opcode = op;
    zero   = z;
    expect_cyc(C_IF, {tag, "_if"});
    expect_cyc(16'h0, {tag, "_id"});
    case (op)
      OP_ADD, OP_SUB, OP_AND: begin
        if (mdepth < 2) expect_cyc(C_FLT, {tag, "_flt"});
        else begin
          expect_cyc(C_POP, {tag, "_p1"});
          expect_cyc(C_POP | C_LDA, {tag, "_p2"});
          expect_cyc(C_LDB, {tag, "_lb"});
          case (op)
            OP_ADD:  expect_cyc(C_PUSH | alu(2'b00), {tag, "_ex"});
            OP_SUB:  expect_cyc(C_PUSH | alu(2'b01), {tag, "_ex"});
            default: expect_cyc(C_PUSH | alu(2'b10), {tag, "_ex"});
          endcase
        end
      end
      OP_NOT: begin
        if (mdepth < 1) expect_cyc(C_FLT, {tag, "_flt"});
        else begin
          expect_cyc(C_POP, {tag, "_p1"});
          expect_cyc(C_LDA, {tag, "_la1"});
          expect_cyc(C_PUSH | alu(2'b11), {tag, "_ex"});
        end
      end
      OP_PUSH: begin
        if (mdepth > 31) expect_cyc(C_FLT, {tag, "_flt"});
        else begin
          expect_cyc(C_MRD | C_IORD | C_LDM, {tag, "_mrd"});
          expect_cyc(C_PUSH | C_STK, {tag, "_pw"});
        end
      end
      OP_POP: begin
        if (mdepth < 1) expect_cyc(C_FLT, {tag, "_flt"});
        else begin
          expect_cyc(C_POP, {tag, "_po"});
          expect_cyc(C_MWR | C_IORD, {tag, "_st"});
        end
      end
      OP_JMP: expect_cyc(C_PCW | C_PCS, {tag, "_jmp"});
      default: begin
        if (mdepth < 1) expect_cyc(C_FLT, {tag, "_flt"});
        else begin
          expect_cyc(C_TOS, {tag, "_tos"});
          expect_cyc(z ? (C_PCW | C_PCS) : 16'h0, {tag, "_jzc"});
        end
      end
    endcase
    drain();
  endtask

  task automatic fault_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      opcode = 3'($urandom_range(0, 7));
      expect_cyc(C_FLT, tag);
      drain();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    mdepth = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    opcode = OP_JMP;
    zero   = 1'b0;
    mdepth = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    instr(OP_PUSH, 1'b0, "push1");
    instr(OP_PUSH, 1'b0, "push2");
    instr(OP_ADD,  1'b0, "add");
    instr(OP_PUSH, 1'b0, "push3");
    instr(OP_SUB,  1'b0, "sub");
    instr(OP_NOT,  1'b0, "not");
    instr(OP_JMP,  1'b0, "jmp");
    instr(OP_JZ,   1'b1, "jz_t");
    instr(OP_JZ,   1'b0, "jz_f");
    instr(OP_PUSH, 1'b0, "push4");
    instr(OP_PUSH, 1'b0, "push5");
    instr(OP_AND,  1'b0, "and");
    instr(OP_PUSH, 1'b0, "push6");
    instr(OP_PUSH, 1'b0, "push7");
    instr(OP_POP,  1'b0, "pop");

    opcode = OP_ADD;
    expect_cyc(C_IF, "mid_if");
    expect_cyc(16'h0, "mid_id");
    expect_cyc(C_POP, "mid_p1");
    drain();
    expect_cyc(C_POP | C_LDA, "mid_p2");
    rst = 1'b1;
    drain();
    rst    = 1'b0;
    mdepth = 0;
    instr(OP_JMP, 1'b0, "post_rst");

    instr(OP_JZ, 1'b1, "jz_empty");
    fault_hold(3, "jz_fault");
    do_reset();

    instr(OP_PUSH, 1'b0, "uf_push");
    instr(OP_ADD,  1'b0, "uf_add");
    fault_hold(4, "uf_fault");
    do_reset();

    for (int i = 0; i < 32; i++) instr(OP_PUSH, 1'b0, "fill");
    instr(OP_PUSH, 1'b0, "of_push");
    fault_hold(3, "of_fault");
    do_reset();
    instr(OP_JMP, 1'b0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_cpu_controller.md
Name: stack_cpu_controller

Overview:
Multicycle FSM controller for the 8-bit stack processor. It fetches and decodes instructions and sequences the 32-entry stack's push/pop/tos strobes, memory, IR/PC and operand registers. It tracks stack depth so the stack never overflows or underflows. It sits beside the datapath and drives every control line from opcode and zero inputs.

Parameters:
STACK_DEPTH, 32, stack entries; the depth counter saturates logic at this value
DEPTH_W, 6, depth counter width, clog2(STACK_DEPTH+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  3  IR[7:5]: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ
zero  in  1  datapath flag; high when the stack output register (resStk) == 0
push  out  1  stack push strobe
pop  out  1  stack pop strobe
tos  out  1  stack read-top strobe
memRead  out  1  memory read enable
memWrite  out  1  memory write enable; data comes from resStk
iorD  out  1  memory address select: 0 = PC, 1 = IR[4:0]
irWrite  out  1  IR load
pcWrite  out  1  PC load
pcSrc  out  1  PC source: 0 = PC+1, 1 = IR[4:0]
ldA  out  1  operand register A load from resStk
ldB  out  1  operand register B load from resStk
ldMdr  out  1  MDR load from memory
stkSrc  out  1  stack dataIn select: 0 = ALU, 1 = MDR
aluOp  out  2  00 add (A+B), 01 sub (B-A), 10 and, 11 not A
depth  out  6  current stack occupancy, 0..32
fault  out  1  sticky stack overflow/underflow error

Behaviour:
- Reset: synchronous, active-high. When rst is high at a rising edge: state=IF, depth=0, fault=0. All outputs except depth are decoded from state and are 0 in reset. rst overrides any in-flight instruction; nothing is held over.
- Moore outputs: every control line is a pure function of state. At most one of push/pop/tos is high in any cycle.
- Stack timing: resStk is registered. A value popped or read in cycle t is valid in cycle t+1.
- States and transitions (each state lasts 1 cycle):
  - IF: memRead, iorD=0, irWrite, pcWrite, pcSrc=0 -> ID
  - ID: no strobes. A stack check runs here:
    - ADD/SUB/AND need depth>=2.
    - NOT, POP and JZ need depth>=1.
    - PUSH needs depth<=STACK_DEPTH-1.
    - JMP has no requirement.
    - A failed check goes to FAULT. Otherwise: ADD/SUB/AND -> P1; NOT -> P1; PUSH -> MRD; POP -> PO; JMP -> JMP; JZ -> TOS.
  - P1: pop -> binary op: P2; NOT: LA1
  - P2: pop, ldA (captures first popped value) -> LB
  - LB: ldB -> EX
  - LA1: ldA -> EX
  - EX: push, stkSrc=0, aluOp from opcode -> IF
  - MRD: memRead, iorD=1, ldMdr -> PW
  - PW: push, stkSrc=1 -> IF
  - PO: pop -> ST
  - ST: memWrite, iorD=1 -> IF
  - JMP: pcWrite, pcSrc=1 -> IF
  - TOS: tos -> JZC
  - JZC: if zero then pcWrite, pcSrc=1 (else PC already holds PC+1) -> IF
  - FAULT: fault=1, no strobes; absorbing until rst.
- Instruction latency in cycles: ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
- depth: +1 on every cycle with push, -1 on every cycle with pop, unchanged otherwise. The ID checks guarantee it never wraps, so it stays in 0..32.
- SUB computes B-A, i.e. second-popped minus top. This matches the order of the operands as pushed.

Decomposition:
- stack_cpu_pkg holds the opcode constants, the state enum (IF, ID, P1, P2, LB, LA1, EX, MRD, PW, PO, ST, JMP, TOS, JZC, FAULT), the aluOp constants and the STACK_DEPTH default.
- One sub-module is natural: stack_depth_tracker. It holds the depth register, applies the push/pop update, and produces the can_pop1, can_pop2 and can_push flags used by ID.
- The FSM next-state and output decode stay in the top module.

Test Plan:
- Reset mid-instruction: assert rst during state P2 -> next cycle state=IF, depth=0, fault=0, all strobes 0.
- PUSH, PUSH, ADD with depth 0: PUSH to PW pushes each; ADD gives pop in P1 and P2, ldA in P2, ldB in LB, push+aluOp=00 in EX. Required: depth goes 1, 2, then 0 after P2, then 1 after EX; total ADD cycles 6.
- JZ with zero=1 at JZC -> pcWrite=1, pcSrc=1. JZ with zero=0 -> pcWrite=0. JZ at depth 0 -> FAULT, and tos is never asserted.
- Underflow: depth=1, ADD -> ID goes to FAULT, fault=1, no pop issued, depth stays 1. fault stays 1 until rst.
- Overflow: 32 PUSHes -> depth=32. The 33rd PUSH -> FAULT with no memRead or push issued.
- POP to memory: depth=3, POP -> pop in PO, memWrite+iorD=1 in ST, depth=2, back to IF after 4 cycles. Check at most one of push/pop/tos per cycle across all scenarios.
